// File: rtl/vga_data_manager_pkg.sv
// rtl/vga_data_manager_pkg.sv - shared states and aux memory map for the VGA frame-refresh engine
package vga_data_manager_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_CTRL,
        ST_READ_IBASE,
        ST_READ_DBASE,
        ST_COPY_CPU,
        ST_COPY_MEM
    } state_t;

    // Aux memory layout: header words, then CPU snapshot, then memory window
    localparam int CTRL_ADDR  = 0;
    localparam int IBASE_ADDR = 1;
    localparam int DBASE_ADDR = 2;
    localparam int CPU_BASE   = 3;
    localparam int MEM_BASE   = 13;

    // Control word bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_SRC_BIT = 1;

endpackage

// File: rtl/vsync_edge_detector.sv
// rtl/vsync_edge_detector.sv - falling-edge detect on the active-low vertical sync
module vsync_edge_detector (
    input  logic clock_in,
    input  logic reset_in,
    input  logic v_sync_in,
    output logic falling_edge
);

    logic v_sync_prev;

    // History register idles high so a sync held low through reset is not seen as an edge
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            v_sync_prev <= 1'b1;
        end else begin
            v_sync_prev <= v_sync_in;
        end
    end

    assign falling_edge = v_sync_prev & ~v_sync_in;

endmodule

// File: rtl/vga_data_manager.sv
// rtl/vga_data_manager.sv - copies CPU registers and a memory window into aux display memory per frame
module vga_data_manager
    import vga_data_manager_pkg::*;
#(
    parameter int DATA_WIDTH           = 16,
    parameter int MEMORY_ADDRESS_WIDTH = 11,
    parameter int AUX_ADDRESS_WIDTH    = 5,
    parameter int CPU_CONTENT_ELEMENTS = 10,
    parameter int MEMORY_ELEMENTS      = 10
) (
    input  logic                            clock_in,
    input  logic                            reset_in,
    input  logic                            v_sync_in,
    input  logic [DATA_WIDTH-1:0]           cpu_content_in,
    input  logic [DATA_WIDTH-1:0]           instruction_memory_in,
    input  logic [DATA_WIDTH-1:0]           data_memory_in,
    input  logic [DATA_WIDTH-1:0]           aux_data_in,
    output logic                            aux_wr_out,
    output logic [DATA_WIDTH-1:0]           aux_data_out,
    output logic [AUX_ADDRESS_WIDTH-1:0]    aux_raddress_out,
    output logic [AUX_ADDRESS_WIDTH-1:0]    aux_waddress_out,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] instruction_address_out,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] data_address_out,
    output logic [CPU_CONTENT_ELEMENTS-1:0] content_enable_out
);

    localparam int MAX_ELEMENTS = (CPU_CONTENT_ELEMENTS > MEMORY_ELEMENTS) ?
                                  CPU_CONTENT_ELEMENTS : MEMORY_ELEMENTS;
    localparam int CNT_WIDTH    = $clog2(MAX_ELEMENTS + 1);

    state_t                          state_q, state_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic [1:0]                      ctrl_q, ctrl_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] ibase_q, ibase_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] dbase_q, dbase_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr;
    logic                            v_sync_fall;
    logic                            unused_bits;

    vsync_edge_detector u_vsync_edge_detector (
        .clock_in     (clock_in),
        .reset_in     (reset_in),
        .v_sync_in    (v_sync_in),
        .falling_edge (v_sync_fall)
    );

    // Header words above the base width carry nothing; the enable bit is consumed on the fly
    assign unused_bits = ^{aux_data_in[DATA_WIDTH-1:MEMORY_ADDRESS_WIDTH], ctrl_q[CTRL_EN_BIT]};

    // Window address wraps naturally at the memory address width
    assign mem_addr = (ctrl_q[CTRL_SRC_BIT] ? dbase_q : ibase_q) + MEMORY_ADDRESS_WIDTH'(cnt_q);

    // State, element counter and latched header fields
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            ibase_q <= '0;
            dbase_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            ibase_q <= ibase_d;
            dbase_q <= dbase_d;
        end
    end

    // Next-state sequencing; sync edges outside IDLE are dropped, not queued
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        ibase_d = ibase_q;
        dbase_d = dbase_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (v_sync_fall) begin
                    state_d = ST_READ_CTRL;
                end
            end
            ST_READ_CTRL: begin
                ctrl_d  = aux_data_in[1:0];
                state_d = aux_data_in[CTRL_EN_BIT] ? ST_READ_IBASE : ST_IDLE;
            end
            ST_READ_IBASE: begin
                ibase_d = aux_data_in[MEMORY_ADDRESS_WIDTH-1:0];
                state_d = ST_READ_DBASE;
            end
            ST_READ_DBASE: begin
                dbase_d = aux_data_in[MEMORY_ADDRESS_WIDTH-1:0];
                cnt_d   = '0;
                state_d = ST_COPY_CPU;
            end
            ST_COPY_CPU: begin
                if (cnt_q == CNT_WIDTH'(CPU_CONTENT_ELEMENTS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_COPY_MEM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COPY_MEM: begin
                if (cnt_q == CNT_WIDTH'(MEMORY_ELEMENTS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state; data is passed straight through
    always_comb begin
        aux_wr_out              = 1'b0;
        aux_data_out            = '0;
        aux_raddress_out        = '0;
        aux_waddress_out        = '0;
        instruction_address_out = '0;
        data_address_out        = '0;
        content_enable_out      = '0;
        unique case (state_q)
            ST_READ_CTRL:  aux_raddress_out = AUX_ADDRESS_WIDTH'(CTRL_ADDR);
            ST_READ_IBASE: aux_raddress_out = AUX_ADDRESS_WIDTH'(IBASE_ADDR);
            ST_READ_DBASE: aux_raddress_out = AUX_ADDRESS_WIDTH'(DBASE_ADDR);
            ST_COPY_CPU: begin
                aux_wr_out         = 1'b1;
                content_enable_out = CPU_CONTENT_ELEMENTS'(1) << cnt_q;
                aux_waddress_out   = AUX_ADDRESS_WIDTH'(CPU_BASE) + AUX_ADDRESS_WIDTH'(cnt_q);
                aux_data_out       = cpu_content_in;
            end
            ST_COPY_MEM: begin
                aux_wr_out       = 1'b1;
                aux_waddress_out = AUX_ADDRESS_WIDTH'(MEM_BASE) + AUX_ADDRESS_WIDTH'(cnt_q);
                if (ctrl_q[CTRL_SRC_BIT]) begin
                    data_address_out = mem_addr;
                    aux_data_out     = data_memory_in;
                end else begin
                    instruction_address_out = mem_addr;
                    aux_data_out            = instruction_memory_in;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_data_manager.sv
// tb/tb_vga_data_manager.sv - directed self-checking bench for vga_data_manager
module tb_vga_data_manager;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        v_sync_in;
    logic [15:0] cpu_content_in;
    logic [15:0] instruction_memory_in;
    logic [15:0] data_memory_in;
    logic [15:0] aux_data_in;
    logic        aux_wr_out;
    logic [15:0] aux_data_out;
    logic [4:0]  aux_raddress_out;
    logic [4:0]  aux_waddress_out;
    logic [10:0] instruction_address_out;
    logic [10:0] data_address_out;
    logic [9:0]  content_enable_out;

    logic [15:0] aux_mem [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;
    int          wr_count = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    vga_data_manager dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .v_sync_in               (v_sync_in),
        .cpu_content_in          (cpu_content_in),
        .instruction_memory_in   (instruction_memory_in),
        .data_memory_in          (data_memory_in),
        .aux_data_in             (aux_data_in),
        .aux_wr_out              (aux_wr_out),
        .aux_data_out            (aux_data_out),
        .aux_raddress_out        (aux_raddress_out),
        .aux_waddress_out        (aux_waddress_out),
        .instruction_address_out (instruction_address_out),
        .data_address_out        (data_address_out),
        .content_enable_out      (content_enable_out)
    );

    always #5 clock_in = ~clock_in;

    // Memory models: combinational reads, tagged contents so the source of each word is visible
    assign aux_data_in           = aux_mem[aux_raddress_out];
    assign instruction_memory_in = 16'hA000 | {5'b0, instruction_address_out};
    assign data_memory_in        = 16'hE000 | {5'b0, data_address_out};

    always_comb begin
        cpu_content_in = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            if (content_enable_out[i]) cpu_content_in = 16'hC000 + 16'(i);
        end
    end

    always @(posedge clock_in) begin
        if (aux_wr_out) begin
            aux_mem[aux_waddress_out] <= aux_data_out;
            wr_count <= wr_count + 1;
        end else if (tb_we) begin
            aux_mem[tb_addr] <= tb_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {5'b0, aux_wr_out, aux_data_out, aux_raddress_out, aux_waddress_out,
                instruction_address_out, data_address_out, content_enable_out};
    endfunction

    task automatic set_aux(input logic [4:0] addr, input logic [15:0] data);
        @(negedge clock_in);
        tb_we = 1'b1; tb_addr = addr; tb_data = data;
        @(negedge clock_in);
        tb_we = 1'b0;
    endtask

    // Drives one sync fall and checks every cycle of an enabled refresh
    task automatic run_refresh(input logic src, input logic [10:0] base, input bit inject_edge);
        logic [10:0] exp_addr;
        int          start_count;
        @(negedge clock_in);
        v_sync_in = 1'b1;
        @(negedge clock_in);
        start_count = wr_count;
        v_sync_in = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock_in);
            if (k <= 3) begin
                check($sformatf("hdr_raddr_k%0d", k), 64'(aux_raddress_out), 64'(k - 1));
                check($sformatf("hdr_wr_k%0d", k), 64'(aux_wr_out), 64'd0);
            end else if (k <= 13) begin
                check($sformatf("cpu_wr_i%0d", k - 4), 64'(aux_wr_out), 64'd1);
                check($sformatf("cpu_waddr_i%0d", k - 4), 64'(aux_waddress_out), 64'(k - 1));
                check($sformatf("cpu_en_i%0d", k - 4), 64'(content_enable_out), 64'(1) << (k - 4));
                check($sformatf("cpu_data_i%0d", k - 4), 64'(aux_data_out), 64'(16'hC000 + 16'(k - 4)));
            end else if (k <= 23) begin
                exp_addr = base + 11'(k - 14);
                check($sformatf("mem_wr_j%0d", k - 14), 64'(aux_wr_out), 64'd1);
                check($sformatf("mem_waddr_j%0d", k - 14), 64'(aux_waddress_out), 64'(k - 1));
                check($sformatf("mem_iaddr_j%0d", k - 14), 64'(instruction_address_out),
                      src ? 64'd0 : 64'(exp_addr));
                check($sformatf("mem_daddr_j%0d", k - 14), 64'(data_address_out),
                      src ? 64'(exp_addr) : 64'd0);
                check($sformatf("mem_data_j%0d", k - 14), 64'(aux_data_out),
                      64'((src ? 16'hE000 : 16'hA000) | {5'b0, exp_addr}));
            end else begin
                check("post_idle_outs", all_outs(), 64'd0);
            end
            if (inject_edge && k == 6) v_sync_in = 1'b1;
            if (inject_edge && k == 8) v_sync_in = 1'b0;
        end
        repeat (3) @(negedge clock_in);
        check("write_count", 64'(wr_count - start_count), 64'd20);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) aux_mem[i] = 16'h0;
        reset_in  = 1'b1;
        v_sync_in = 1'b1;
        repeat (3) @(negedge clock_in);
        check("reset_outs", all_outs(), 64'd0);
        reset_in = 1'b0;
        @(negedge clock_in);
        check("idle_outs", all_outs(), 64'd0);

        // Enabled refresh from instruction memory, base 0
        set_aux(5'd0, 16'h0001);
        set_aux(5'd1, 16'h0000);
        set_aux(5'd2, 16'h07FF);
        run_refresh(1'b0, 11'h000, 1'b0);
        check("aux3", 64'(aux_mem[3]), 64'hC000);
        check("aux12", 64'(aux_mem[12]), 64'hC009);
        check("aux13", 64'(aux_mem[13]), 64'hA000);
        check("aux22", 64'(aux_mem[22]), 64'hA009);
        check("aux23_untouched", 64'(aux_mem[23]), 64'h0000);

        // Data window wrapping past the top of memory, with a sync edge injected mid-copy
        set_aux(5'd0, 16'h0003);
        run_refresh(1'b1, 11'h7FF, 1'b1);
        check("wrap_aux13", 64'(aux_mem[13]), 64'hE7FF);
        check("wrap_aux14", 64'(aux_mem[14]), 64'hE000);
        check("wrap_aux22", 64'(aux_mem[22]), 64'hE008);
        check("wrap_idle_after", all_outs(), 64'd0);

        // Disabled refresh: header read only, no writes
        begin
            int c0;
            set_aux(5'd0, 16'h0000);
            @(negedge clock_in);
            v_sync_in = 1'b1;
            @(negedge clock_in);
            c0 = wr_count;
            v_sync_in = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clock_in);
                check($sformatf("dis_wr_k%0d", k), 64'(aux_wr_out), 64'd0);
                check($sformatf("dis_raddr_k%0d", k), 64'(aux_raddress_out), 64'd0);
            end
            check("dis_write_count", 64'(wr_count - c0), 64'd0);
        end

        // Reset mid COPY_CPU aborts; next sync fall runs a complete sequence
        begin
            int c0;
            set_aux(5'd0, 16'h0001);
            @(negedge clock_in);
            v_sync_in = 1'b1;
            @(negedge clock_in);
            v_sync_in = 1'b0;
            repeat (6) @(negedge clock_in);
            check("pre_reset_in_copy", 64'(aux_wr_out), 64'd1);
            reset_in = 1'b1;
            #1;
            check("async_reset_outs", all_outs(), 64'd0);
            c0 = wr_count;
            v_sync_in = 1'b1;
            repeat (3) @(negedge clock_in);
            check("reset_no_writes", 64'(wr_count - c0), 64'd0);
            reset_in = 1'b0;
            repeat (2) @(negedge clock_in);
            check("post_reset_idle", all_outs(), 64'd0);
            run_refresh(1'b0, 11'h000, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
